// File: rtl/seg7_display_bank.sv
// Multi-digit 7-segment bank driver: shadowed digit/dp capture, leading-zero blanking, per-digit blink.
// Optional macro SEG7_HEX_GLYPHS_EN renders codes 10..15 as hex letters instead of a dash.
module seg7_display_bank #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BLINK_DIV  = 25_000_000,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz_en,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [7*NUM_DIGITS-1:0]   seg_out,
  output logic [NUM_DIGITS-1:0]     dp_out
);

  localparam int unsigned CNT_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned SEG_W   = 7 * NUM_DIGITS;
  localparam int unsigned DIG_W   = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  localparam logic        POL_INV = (ACTIVE_LOW == 0);
  localparam logic [6:0]  GLYPH_BLANK = 7'h7F;

  logic [DIG_W-1:0]      shadow_digits;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [CNT_W-1:0]      blink_cnt;
  logic                  blink_phase;
  logic [SEG_W-1:0]      seg_nxt_c;
  logic [NUM_DIGITS-1:0] dp_nxt_c;

  // Active-low glyph for one code; polarity is applied on the whole word afterwards.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
`ifdef SEG7_HEX_GLYPHS_EN
      4'd10:   g = 7'h08;
      4'd11:   g = 7'h03;
      4'd12:   g = 7'h46;
      4'd13:   g = 7'h21;
      4'd14:   g = 7'h06;
      default: g = 7'h0E;
`else
      default: g = 7'h3F;
`endif
    endcase
    return g;
  endfunction

  // Next output word from the shadow, live controls and current blink phase.
  always_comb begin
    logic       nz_seen;
    logic       lz_blank;
    logic       blink_off;
    logic [3:0] code;
    seg_nxt_c = '0;
    dp_nxt_c  = '0;
    nz_seen   = 1'b0;
    lz_blank  = 1'b0;
    blink_off = 1'b0;
    code      = 4'd0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      code      = shadow_digits[4*i +: 4];
      if (code != 4'd0) nz_seen = 1'b1;
      lz_blank  = blank_lz_en && !nz_seen && (i != 0);
      blink_off = blink_phase && blink_mask[i];
      seg_nxt_c[7*i +: 7] = (blink_off || lz_blank) ? GLYPH_BLANK : glyph(code);
      dp_nxt_c[i]         = blink_off ? 1'b1 : ~shadow_dp[i];
    end
    seg_nxt_c = seg_nxt_c ^ {SEG_W{POL_INV}};
    dp_nxt_c  = dp_nxt_c ^ {NUM_DIGITS{POL_INV}};
  end

  // Shadow capture, free-running blink prescaler and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
      seg_out       <= {SEG_W{~POL_INV}};
      dp_out        <= {NUM_DIGITS{~POL_INV}};
    end else begin
      if (load) begin
        shadow_digits <= digits_in;
        shadow_dp     <= dp_in;
      end
      if (blink_cnt == CNT_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
      seg_out <= seg_nxt_c;
      dp_out  <= dp_nxt_c;
    end
  end

endmodule
